addition: RTL and testbench

Parameterised ripple-carry binary adder with registered outputs. It is the add datapath slice of the integer ALU. It computes a + b + carry_in and presents the sum, carry-out and signed-overflow one clock after the operands are sampled. A valid strobe accompanies the operands and the result.

---
 rtl/addition_pkg.sv | 4 +
 rtl/full_adder.sv | 11 +
 rtl/addition.sv | 46 ++++
 tb/tb_addition.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/addition_pkg.sv
// addition_pkg: shared ALU constants for the add datapath slice
package addition_pkg;
  localparam int ALU_WIDTH = 4;
endpackage

// File: rtl/full_adder.sv
// full_adder: 1-bit combinational full-adder cell
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/addition.sv
// addition: ripple-carry adder with registered sum, carry-out, signed overflow and valid
module addition
  import addition_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  assign c[0] = carry_in;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .x   (a[i]),
      .y   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end
  // result registers load only on valid; valid itself follows in_valid every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= s;
        carry_out <= c[WIDTH];
        overflow  <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_addition.sv
// tb_addition: table-driven and scoreboard checks of the registered adder
module tb_addition;
  localparam int W = 4;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, carry_in = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic         carry_out, overflow, out_valid;
  typedef struct packed {logic [W-1:0] sum; logic co; logic ov;} res_t;
  typedef struct {logic [W-1:0] a; logic [W-1:0] b; logic ci; res_t exp;} vec_t;
  res_t sb[$];
  vec_t tbl[$];
  res_t last = '0;
  int   n_cmp = 0, n_bad = 0;

  addition #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .carry_in(carry_in),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] full;
    res_t r;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    r.sum = full[W-1:0];
    r.co  = full[W];
    r.ov  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
    return r;
  endfunction

  function automatic vec_t mk(input int x, input int y, input int ci, input int s, input int co, input int ov);
    vec_t v;
    v.a = x[W-1:0]; v.b = y[W-1:0]; v.ci = ci[0];
    v.exp.sum = s[W-1:0]; v.exp.co = co[0]; v.exp.ov = ov[0];
    return v;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input res_t e);
    in_valid = v; a = x; b = y; carry_in = ci;
    if (v) sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_co"}, carry_out, 0);
    chk({tag, "_ov"}, overflow, 0);
    chk({tag, "_valid"}, out_valid, 0);
  endtask

  task automatic tick();
    logic v;
    res_t e;
    v = in_valid && rst_n;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, v);
    if (!rst_n) check_zero("in_reset");
    else if (out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_result: got sum %0h with empty scoreboard", sum);
      end else begin
        e = sb.pop_front();
        chk("sum", sum, e.sum);
        chk("carry_out", carry_out, e.co);
        chk("overflow", overflow, e.ov);
        last = e;
      end
    end else begin
      chk("hold_sum", sum, last.sum);
      chk("hold_co", carry_out, last.co);
      chk("hold_ov", overflow, last.ov);
    end
  endtask

  initial begin
    tbl.push_back(mk(0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 2, 0, 0));
    tbl.push_back(mk(2, 2, 0, 4, 0, 0));
    tbl.push_back(mk(3, 1, 0, 4, 0, 0));
    tbl.push_back(mk(15, 1, 0, 0, 1, 0));
    tbl.push_back(mk(15, 15, 1, 15, 1, 0));
    tbl.push_back(mk(7, 8, 1, 0, 1, 0));
    tbl.push_back(mk(7, 1, 0, 8, 0, 1));
    tbl.push_back(mk(8, 8, 0, 0, 1, 1));
    tbl.push_back(mk(15, 1, 0, 0, 1, 0));
    // asynchronous reset visible before any clock edge
    in_valid = 1'b1; a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
    #3;
    check_zero("reset_async");
    tick();
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    // table vectors, back-to-back
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].exp);
      tick();
    end
    // single pulse then idle with all-ones operands: result must hold
    drive(1'b1, 4'd5, 4'd6, 1'b0, '{sum: 4'd11, co: 1'b0, ov: 1'b1});
    tick();
    drive(1'b0, 4'hF, 4'hF, 1'b1, '0);
    tick();
    tick();
    tick();
    // 16 consecutive random valids
    for (int i = 0; i < 16; i++) begin
      a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
      drive(1'b1, a, b, carry_in, model(a, b, carry_in));
      tick();
    end
    // reset dropped while a result is live on the outputs
    drive(1'b1, 4'd9, 4'd9, 1'b0, model(4'd9, 4'd9, 1'b0));
    tick();
    drive(1'b1, 4'd3, 4'd4, 1'b1, model(4'd3, 4'd4, 1'b1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    sb.delete();
    last = '0;
    tick();
    rst_n = 1'b1;
    drive(1'b1, 4'd6, 4'd7, 1'b0, model(4'd6, 4'd7, 1'b0));
    tick();
    // exhaustive sweep of a, b, carry_in
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, i[3:0], i[7:4], i[8], model(i[3:0], i[7:4], i[8]));
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
